// File: rtl/uartrx_pkg.sv
// Shared types and defaults for the UART receive frame engine.
package uartrx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    LOAD
  } uartrx_rx_state_t;

  localparam int UARTRX_CLKS_PER_BIT = 10;
  localparam int UARTRX_DATA_BITS    = 8;

endpackage

// File: rtl/uartrx_bit_timer.sv
// Per-bit cycle counter giving mid-start and end-of-bit ticks.
module uartrx_bit_timer
  import uartrx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UARTRX_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic half_tick,
  output logic full_tick
);

  localparam int W    = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;

  localparam logic [W-1:0] HALF_M1 = W'(HALF - 1);
  localparam logic [W-1:0] LAST    = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign half_tick = enable && (cnt == HALF_M1);
  assign full_tick = enable && (cnt == LAST);

endmodule

// File: rtl/uartrx_frame_receiver.sv
// UART RX frame engine: samples start/data/stop bits after the
// start detector fires and reports byte, ready and error status.
module uartrx_frame_receiver
  import uartrx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UARTRX_CLKS_PER_BIT,
  parameter int DATA_BITS    = UARTRX_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
  input  logic                 start_bit_detected,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 framing_error,
  output logic                 overrun_error
);

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  uartrx_rx_state_t state, state_next;

  logic                 sync1;
  logic                 line_s;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 stop_ok;

  logic timer_clear;
  logic timer_en;
  logic half_tick;
  logic full_tick;
  logic shift_en;
  logic stop_en;
  logic load;
  logic fe_clr;

  uartrx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (timer_clear),
    .enable   (timer_en),
    .half_tick(half_tick),
    .full_tick(full_tick)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1  <= 1'b1;
      line_s <= 1'b1;
    end else begin
      sync1  <= serial_in;
      line_s <= sync1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start_bit_detected) state_next = START;
      START: if (half_tick) state_next = line_s ? IDLE : DATA;
      DATA:  if (full_tick && bit_cnt == LAST_BIT)
               state_next = STOP;
      STOP:  if (full_tick) state_next = LOAD;
      LOAD:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    timer_clear = (state_next != state);
    timer_en    = 1'b0;
    shift_en    = 1'b0;
    stop_en     = 1'b0;
    load        = 1'b0;
    fe_clr      = 1'b0;
    unique case (state)
      IDLE:  fe_clr = start_bit_detected;
      START: timer_en = 1'b1;
      DATA: begin
        timer_en = 1'b1;
        shift_en = full_tick;
      end
      STOP: begin
        timer_en = 1'b1;
        stop_en  = full_tick;
      end
      LOAD:  load = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
      stop_ok <= 1'b0;
    end else begin
      if (state != DATA) bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 1'b1;
      if (shift_en)
        shreg <= {line_s, shreg[DATA_BITS-1:1]};
      if (stop_en) stop_ok <= line_s;
    end
  end

  // A good load beats a coincident read: ready stays set.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data       <= '0;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      if (fe_clr) framing_error <= 1'b0;
      unique case (1'b1)
        load && stop_ok: begin
          rx_data    <= shreg;
          data_ready <= 1'b1;
          if (data_read)       overrun_error <= 1'b0;
          else if (data_ready) overrun_error <= 1'b1;
        end
        default: begin
          if (load) framing_error <= 1'b1;
          if (data_read) begin
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uartrx_frame_receiver.sv
// Self-checking bench for uartrx_frame_receiver: vector table,
// hand-written corner cases and random frames vs. a byte-level model.
module tb_uartrx_frame_receiver;
  import uartrx_pkg::*;

  localparam int CPB = 10;
  localparam int DB  = 8;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          serial_in = 1'b1;
  logic          sbd = 1'b0;
  logic          data_read = 1'b0;
  logic [DB-1:0] rx_data;
  logic          data_ready;
  logic          framing_error;
  logic          overrun_error;

  uartrx_frame_receiver #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB)
  ) dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .serial_in         (serial_in),
    .start_bit_detected(sbd),
    .data_read         (data_read),
    .rx_data           (rx_data),
    .data_ready        (data_ready),
    .framing_error     (framing_error),
    .overrun_error     (overrun_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [7:0] m_data;
  logic       m_ready;
  logic       m_fe;
  logic       m_ov;

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic       rd_load;
    logic       pre_read;
    logic [7:0] ed;
    logic       er;
    logic       efe;
    logic       eov;
  } vec_t;

  vec_t tbl[7];

  task automatic check_out(input string name, input logic [7:0] d,
                           input logic r, input logic fe,
                           input logic ov);
    checks++;
    if ({rx_data, data_ready, framing_error, overrun_error}
        === {d, r, fe, ov})
      passes++;
    else
      $display("FAIL %s: got data=%h rdy=%b fe=%b ov=%b, want data=%h rdy=%b fe=%b ov=%b",
               name, rx_data, data_ready, framing_error,
               overrun_error, d, r, fe, ov);
  endtask

  task automatic check_model(input string name);
    check_out(name, m_data, m_ready, m_fe, m_ov);
  endtask

  task automatic model_reset();
    m_data  = '0;
    m_ready = 1'b0;
    m_fe    = 1'b0;
    m_ov    = 1'b0;
  endtask

  task automatic read_pulse();
    @(posedge clk); #1 data_read = 1'b1;
    @(posedge clk); #1 data_read = 1'b0;
    m_ready = 1'b0;
    m_ov    = 1'b0;
    check_model("read_clear");
  endtask

  // Edge i counts from the edge that launched the start bit.
  task automatic frame(input logic [7:0] b, input logic stop,
                       input logic rd_load, input int rst_at,
                       input string name);
    bit aborted;
    aborted = 1'b0;
    @(posedge clk); #1 serial_in = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (i == 2) sbd = 1'b1;
      if (i == 3) begin
        sbd  = 1'b0;
        m_fe = 1'b0;
      end
      if (i >= 10 && i <= 80 && i % 10 == 0)
        serial_in = b[i/10-1];
      if (i == 90) serial_in = stop;
      if (i == 100) serial_in = 1'b1;
      if (i == 98 && rd_load) data_read = 1'b1;
      if (i == 99) data_read = 1'b0;
      if (i == rst_at) begin
        n_rst = 1'b0;
        #1;
        model_reset();
        check_model($sformatf("%s:async_rst", name));
        #2 n_rst = 1'b1;
        aborted = 1'b1;
      end
      if (i == 98 && !aborted)
        check_model($sformatf("%s:pre_load", name));
      if (i == 99 && !aborted) begin
        if (stop) begin
          if (rd_load)      m_ov = 1'b0;
          else if (m_ready) m_ov = 1'b1;
          m_ready = 1'b1;
          m_data  = b;
        end else begin
          m_fe = 1'b1;
          if (rd_load) begin
            m_ready = 1'b0;
            m_ov    = 1'b0;
          end
        end
        check_model($sformatf("%s:post_load", name));
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic glitch(input string name);
    @(posedge clk); #1 serial_in = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 2) sbd = 1'b1;
      if (i == 3) begin
        sbd       = 1'b0;
        serial_in = 1'b1;
        m_fe      = 1'b0;
      end
    end
    check_model(name);
  endtask

  initial begin
    model_reset();
    tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{8'h11, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{8'h55, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'h0F, 1'b1, 1'b0, 1'b0, 8'h0F, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{8'h99, 1'b1, 1'b1, 1'b0, 8'h99, 1'b1, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1 check_out("reset_state", 8'h00, 1'b0, 1'b0, 1'b0);
    n_rst = 1'b1;
    repeat (4) @(posedge clk);
    #1 check_out("idle_after_reset", 8'h00, 1'b0, 1'b0, 1'b0);

    for (int v = 0; v < 7; v++) begin
      if (tbl[v].pre_read) read_pulse();
      frame(tbl[v].b, tbl[v].stop, tbl[v].rd_load, -1,
            $sformatf("vec%0d", v));
      check_out($sformatf("vec%0d_table", v), tbl[v].ed,
                tbl[v].er, tbl[v].efe, tbl[v].eov);
    end

    glitch("glitch");
    check_out("glitch_table", 8'h99, 1'b1, 1'b0, 1'b0);

    frame(8'h77, 1'b1, 1'b0, 55, "abort");
    check_out("abort_table", 8'h00, 1'b0, 1'b0, 1'b0);
    frame(8'hC3, 1'b1, 1'b0, -1, "after_rst");
    check_out("after_rst_table", 8'hC3, 1'b1, 1'b0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      logic [7:0] b;
      logic       stop;
      logic       rdl;
      b    = 8'($urandom);
      stop = ($urandom % 4) != 0;
      rdl  = ($urandom % 3) == 0;
      if ($urandom % 3 == 0) read_pulse();
      if ($urandom % 5 == 0) glitch($sformatf("rnd%0d_glitch", n));
      frame(b, stop, rdl, -1, $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uartrx_frame_receiver.md
# uartrx_frame_receiver

Receive-side frame engine of the UART RX path, directly downstream of the start bit detector. It consumes `start_bit_detected` and the raw serial line, times mid-bit sample points, and shifts in LSB-first data bits. It checks the start and stop bits and presents a completed byte with ready, framing-error and overrun status to the bus/FIFO side.

## Interface
- `CLKS_PER_BIT`, 10: clock cycles per serial bit; must be ≥ 4.
- `DATA_BITS`, 8: data bits per frame; range 5–8.
- `clk` in 1: system clock; all state is updated on the rising edge.
- `n_rst` in 1: reset, asynchronous, active-low.
- `serial_in` in 1: raw RX line (idle high); the same net that feeds the start bit detector.
- `start_bit_detected` in 1: one-cycle pulse from the start bit detector.
- `data_read` in 1: consumer acknowledges `rx_data`.
- `rx_data` out DATA_BITS: last accepted byte.
- `data_ready` out 1: `rx_data` is valid and unread.
- `framing_error` out 1: last frame's stop bit sampled 0.
- `overrun_error` out 1: an unread byte was overwritten.

## Operation
- Internal 2-flop synchronizer on `serial_in`, reset to 1. Its output `line_s` has the same latency as the detector's compare stage, so `line_s` = 0 in the cycle `start_bit_detected` = 1.
- Bit timer counts 0..CLKS_PER_BIT-1, wraps to 0, and is cleared on every state entry. HALF = CLKS_PER_BIT/2 (integer division).
- States:
  - IDLE: on `start_bit_detected`, clear the timer, clear `framing_error`, go to START.
  - START: when timer = HALF-1, sample `line_s`. 0 → DATA (timer and bit counter cleared). 1 → false start, back to IDLE, no status change.
  - DATA: at each timer = CLKS_PER_BIT-1, sample `line_s` into the shift register MSB and shift right (LSB first); bit counter +1. After DATA_BITS samples → STOP.
  - STOP: at timer = CLKS_PER_BIT-1, sample `line_s`. Latch `stop_ok` and go to LOAD.
  - LOAD: single cycle, then IDLE.
    - If `stop_ok`: `rx_data` ← shift register, `data_ready` ← 1. If `data_ready` = 1 and `data_read` = 0 in this cycle, `overrun_error` ← 1.
    - If not `stop_ok`: `framing_error` ← 1; `rx_data`, `data_ready` and `overrun_error` are unchanged.
- `start_bit_detected` is ignored outside IDLE.
- `data_read` = 1: clears `data_ready` and `overrun_error` at the next edge. If `data_read` coincides with a LOAD, the load wins: `data_ready` stays 1, and `overrun_error` is cleared, not set.
- Bit counter width is $clog2(DATA_BITS+1). Timer width is $clog2(CLKS_PER_BIT).

## Timing
- Reset values: state IDLE, `rx_data` all 0, `data_ready` 0, `framing_error` 0, `overrun_error` 0. Synchronizer, shift register and counters are cleared.
- With detection pulse in cycle d:
  - Start sample at edge d+HALF.
  - Data bit k (k = 0..DATA_BITS-1) sampled at edge d+HALF+(k+1)·CLKS_PER_BIT.
  - Stop bit sampled at edge S = d+HALF+(DATA_BITS+1)·CLKS_PER_BIT.
  - LOAD occupies cycle S+1. Outputs update at the end of S+1 and are visible from S+2.
- Back-to-back frames: IDLE is re-entered in cycle S+2. A detector pulse in S+2 or later is accepted.
- Reset asserted mid-frame aborts immediately. Outputs take reset values asynchronously, and the partial byte is discarded.

## Structure
- Package `uartrx_pkg`:
  - state enum `uartrx_rx_state_t` {IDLE, START, DATA, STOP, LOAD};
  - default constants `UARTRX_CLKS_PER_BIT` = 10 and `UARTRX_DATA_BITS` = 8.
- Sub-module `uartrx_bit_timer`:
  - parameter `CLKS_PER_BIT`;
  - inputs `clear`, `enable`;
  - outputs `half_tick` (count = HALF-1) and `full_tick` (count = CLKS_PER_BIT-1, then wrap).
- FSM, synchronizer, shift register and status flags live in the top.

## Test plan
All scenarios use CLKS_PER_BIT = 10 and DATA_BITS = 8, with the detector instantiated alongside and driven from the same `serial_in`.
- Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) → `rx_data` = 0xA5 and `data_ready` = 1 from cycle d+97. Both errors stay 0.
- 3-cycle low glitch on an idle line → detector pulses, start sample reads 1, FSM returns to IDLE. `data_ready`, `rx_data` and both errors are unchanged.
- Frame 0x3C with stop bit 0 → `framing_error` = 1, `data_ready` = 0, `rx_data` unchanged. A following valid frame 0x11 clears `framing_error` and gives `rx_data` = 0x11.
- Frames 0x55 then 0x0F with no `data_read` → after the second, `rx_data` = 0x0F, `data_ready` = 1, `overrun_error` = 1. A `data_read` pulse then clears both flags next edge.
- `data_read` asserted exactly in the second frame's LOAD cycle → `data_ready` = 1, `overrun_error` = 0, `rx_data` = second byte.
- `n_rst` pulsed low during data bit 4 of a frame → all outputs reset immediately. A subsequent 0xC3 frame is received correctly.
